// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the single-master interconnect: transfer encodings,
// fault causes and the data-phase owner encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } transfer_kind_e;

  typedef logic [2:0] transfer_size_t;
  typedef logic [2:0] transfer_burst_t;
  typedef logic [3:0] transfer_protection_t;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } transfer_response_e;

  typedef enum logic [1:0] {
    CauseUnmapped = 2'd0,
    CauseReadOnly = 2'd1,
    CausePriv     = 2'd2
  } fault_cause_e;

  typedef enum logic [1:0] {
    SelNone,
    SelDefault,
    SelDevice
  } sel_kind_e;

  // Data-phase owner: idx is only meaningful when kind is SelDevice.
  typedef struct packed {
    sel_kind_e  kind;
    logic [3:0] idx;
  } data_sel_t;

  localparam data_sel_t DataSelNone = '{kind: SelNone, idx: 4'd0};
  localparam int unsigned MaxDevices = 16;

endpackage

// File: rtl/ahb_interconnect_if.sv
// AHB-Lite bus bundle between one master, the interconnect and DEVICE_COUNT slaves.
// The interconnect takes the slave modport; the environment (master + devices) the master one.
interface ahb_interconnect_if
  import ahb_pkg::*;
#(
  parameter int unsigned DEVICE_COUNT = 2
);
  logic [31:0]                          m_addr;
  transfer_kind_e                       m_trans;
  logic                                 m_write;
  transfer_protection_t                 m_prot;
  logic [DEVICE_COUNT-1:0]              s_sel;
  logic [DEVICE_COUNT-1:0][31:0]        s_rdata;
  logic [DEVICE_COUNT-1:0]              s_ready;
  transfer_response_e [DEVICE_COUNT-1:0] s_resp;
  logic [31:0]                          m_rdata;
  logic                                 m_ready;
  transfer_response_e                   m_resp;

  modport slave (
    input  m_addr, m_trans, m_write, m_prot, s_rdata, s_ready, s_resp,
    output s_sel, m_rdata, m_ready, m_resp
  );

  modport master (
    output m_addr, m_trans, m_write, m_prot, s_rdata, s_ready, s_resp,
    input  s_sel, m_rdata, m_ready, m_resp
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR response for faulting transfers and
// capture of the most recent fault (address, cause, saturating count).
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic               clock_i,
  input  logic               nreset_i,
  input  logic               fault_accept_i,
  input  fault_cause_e       cause_i,
  input  logic [31:0]        addr_i,
  output logic               ready_o,
  output transfer_response_e resp_o,
  output logic [15:0]        err_count_o,
  output logic [31:0]        err_addr_o,
  output fault_cause_e       err_cause_o
);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

  state_e       state_q, state_d;
  logic [15:0]  count_q, count_d;
  logic [31:0]  addr_q, addr_d;
  fault_cause_e cause_q, cause_d;

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      cause_q <= CauseUnmapped;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b1;
    resp_o  = RespOkay;
    unique case (state_q)
      StIdle: if (fault_accept_i) state_d = StErr1;
      StErr1: begin
        ready_o = 1'b0;
        resp_o  = RespError;
        state_d = StErr2;
      end
      StErr2: begin
        resp_o  = RespError;
        state_d = fault_accept_i ? StErr1 : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    cause_d = cause_q;
    if (fault_accept_i) begin
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      addr_d  = addr_i;
      cause_d = cause_i;
    end
  end

  assign err_count_o = count_q;
  assign err_addr_o  = addr_q;
  assign err_cause_o = cause_q;

endmodule

// File: rtl/ahb_interconnect.sv
// AHB-Lite single-master interconnect: address-map decode with access checks,
// registered data-phase owner and read/ready/response return mux.
module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter int unsigned                   DEVICE_COUNT = 2,
  parameter logic [DEVICE_COUNT-1:0][31:0] ADDR_BASE    = {32'h0000_0800, 32'h0000_0000},
  parameter logic [DEVICE_COUNT-1:0][31:0] ADDR_SIZE    = {32'h0000_0800, 32'h0000_0800},
  parameter logic [DEVICE_COUNT-1:0]       READ_ONLY    = '0,
  parameter logic [DEVICE_COUNT-1:0]       PRIV_ONLY    = '0
) (
  input  logic              clock_i,
  input  logic              nreset_i,
  ahb_interconnect_if.slave bus,
  output logic [15:0]       err_count_o,
  output logic [31:0]       err_addr_o,
  output fault_cause_e      err_cause_o
);

  if (DEVICE_COUNT < 1 || DEVICE_COUNT > MaxDevices) begin : g_bad_count
    $fatal(1, "DEVICE_COUNT must be in 1..16");
  end
  for (genvar g = 0; g < DEVICE_COUNT; g++) begin : g_check_map
    if (ADDR_SIZE[g] == 32'd0 || (ADDR_SIZE[g] & (ADDR_SIZE[g] - 32'd1)) != 32'd0) begin : g_size
      $fatal(1, "ADDR_SIZE entry is not a power of two");
    end
    if ((ADDR_BASE[g] & (ADDR_SIZE[g] - 32'd1)) != 32'd0) begin : g_align
      $fatal(1, "ADDR_BASE entry is not aligned to its size");
    end
  end

  logic                    hit, ro, po, fault, active, accept, fault_accept;
  logic [3:0]              hit_idx;
  logic [DEVICE_COUNT-1:0] dev_oh;
  fault_cause_e            cause;
  data_sel_t               data_sel_q, data_sel_d;
  logic                    ds_ready;
  transfer_response_e      ds_resp;
  logic                    unused_prot;

  assign unused_prot = ^{bus.m_prot[3:2], bus.m_prot[0]};

  // Scan from the top so the lowest-index overlapping region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    dev_oh  = '0;
    ro      = 1'b0;
    po      = 1'b0;
    for (int i = int'(DEVICE_COUNT) - 1; i >= 0; i--) begin
      if ((bus.m_addr - ADDR_BASE[i]) < ADDR_SIZE[i]) begin
        hit       = 1'b1;
        hit_idx   = 4'(i);
        dev_oh    = '0;
        dev_oh[i] = 1'b1;
        ro        = READ_ONLY[i];
        po        = PRIV_ONLY[i];
      end
    end
  end

  always_comb begin
    fault = 1'b1;
    cause = CauseUnmapped;
    if (hit) begin
      if (bus.m_write && ro)         cause = CauseReadOnly;
      else if (!bus.m_prot[1] && po) cause = CausePriv;
      else                           fault = 1'b0;
    end
  end

  assign bus.s_sel    = (nreset_i && hit && !fault) ? dev_oh : '0;
  assign active       = (bus.m_trans == TransNonseq) || (bus.m_trans == TransSeq);
  assign accept       = bus.m_ready;
  assign fault_accept = accept && active && fault;

  always_comb begin
    data_sel_d = data_sel_q;
    if (accept) begin
      if (!active)    data_sel_d = DataSelNone;
      else if (fault) data_sel_d = '{kind: SelDefault, idx: 4'd0};
      else            data_sel_d = '{kind: SelDevice, idx: hit_idx};
    end
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) data_sel_q <= DataSelNone;
    else           data_sel_q <= data_sel_d;
  end

  always_comb begin
    bus.m_ready = 1'b1;
    bus.m_resp  = RespOkay;
    bus.m_rdata = '0;
    unique case (data_sel_q.kind)
      SelNone: ;
      SelDefault: begin
        bus.m_ready = ds_ready;
        bus.m_resp  = ds_resp;
      end
      SelDevice: begin
        for (int i = 0; i < int'(DEVICE_COUNT); i++) begin
          if (data_sel_q.idx == 4'(i)) begin
            bus.m_ready = bus.s_ready[i];
            bus.m_resp  = bus.s_resp[i];
            bus.m_rdata = bus.s_rdata[i];
          end
        end
      end
      default: ;
    endcase
  end

  ahb_default_slave u_default_slave (
    .clock_i        (clock_i),
    .nreset_i       (nreset_i),
    .fault_accept_i (fault_accept),
    .cause_i        (cause),
    .addr_i         (bus.m_addr),
    .ready_o        (ds_ready),
    .resp_o         (ds_resp),
    .err_count_o    (err_count_o),
    .err_addr_o     (err_addr_o),
    .err_cause_o    (err_cause_o)
  );

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed bench for ahb_interconnect: decode, stalls, default-slave errors,
// access protection and asynchronous reset, with hand-computed expectations.
module tb_ahb_interconnect;
  import ahb_pkg::*;

  logic         clock;
  logic         nreset;
  logic [15:0]  err_count;
  logic [31:0]  err_addr;
  fault_cause_e err_cause;
  int           compared = 0;
  int           mismatched = 0;

  ahb_interconnect_if #(.DEVICE_COUNT(2)) bus ();

  ahb_interconnect #(
    .DEVICE_COUNT (2),
    .ADDR_BASE    ({32'h0000_0800, 32'h0000_0000}),
    .ADDR_SIZE    ({32'h0000_0800, 32'h0000_0800}),
    .READ_ONLY    (2'b01),
    .PRIV_ONLY    (2'b10)
  ) dut (
    .clock_i     (clock),
    .nreset_i    (nreset),
    .bus         (bus.slave),
    .err_count_o (err_count),
    .err_addr_o  (err_addr),
    .err_cause_o (err_cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input transfer_kind_e trans,
                       input logic write, input logic [3:0] prot);
    bus.m_addr  = addr;
    bus.m_trans = trans;
    bus.m_write = write;
    bus.m_prot  = prot;
  endtask

  task automatic check_err(input string tag, input logic [15:0] cnt, input logic [31:0] addr,
                           input logic [1:0] cause);
    check({tag, "_count"}, 32'(err_count), 32'(cnt));
    check({tag, "_addr"}, err_addr, addr);
    check({tag, "_cause"}, 32'(err_cause), 32'(cause));
  endtask

  task automatic check_phase(input string tag, input logic ready, input logic resp,
                             input logic [31:0] rdata);
    check({tag, "_ready"}, 32'(bus.m_ready), 32'(ready));
    check({tag, "_resp"}, 32'(bus.m_resp), 32'(resp));
    check({tag, "_rdata"}, bus.m_rdata, rdata);
  endtask

  initial begin
    nreset      = 1'b0;
    bus.s_ready = 2'b11;
    bus.s_resp  = {RespOkay, RespOkay};
    bus.s_rdata = '0;
    drive(32'h10, TransIdle, 1'b0, 4'b0011);
    #2;
    check("rst_sel", 32'(bus.s_sel), 32'h0);
    check_phase("rst", 1'b1, 1'b0, 32'h0);
    check_err("rst", 16'd0, 32'h0, 2'd0);
    #1 nreset = 1'b1;
    tick();

    // 1: zero-wait read from device 0
    drive(32'h10, TransNonseq, 1'b0, 4'b0011);
    bus.s_rdata[0] = 32'hDEADBEEF;
    #1 check("t1_sel", 32'(bus.s_sel), 32'h1);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t1_data", 1'b1, 1'b0, 32'hDEADBEEF);

    // 2: device 1 stalls three cycles while the next address waits
    drive(32'h900, TransNonseq, 1'b0, 4'b0011);
    bus.s_rdata[1] = 32'hCAFE0900;
    #1 check("t2_sel", 32'(bus.s_sel), 32'h2);
    tick();
    bus.s_ready[1] = 1'b0;
    bus.s_rdata[0] = 32'h11110000;
    drive(32'h10, TransNonseq, 1'b0, 4'b0011);
    #1 check_phase("t2_stall1", 1'b0, 1'b0, 32'hCAFE0900);
    tick();
    check("t2_stall2", 32'(bus.m_ready), 32'h0);
    tick();
    check("t2_stall3", 32'(bus.m_ready), 32'h0);
    tick();
    bus.s_ready[1] = 1'b1;
    #1 check_phase("t2_done", 1'b1, 1'b0, 32'hCAFE0900);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t2_next", 1'b1, 1'b0, 32'h11110000);
    check("t2_nocount", 32'(err_count), 32'h0);

    // 3: unmapped read
    drive(32'h2000, TransNonseq, 1'b0, 4'b0011);
    #1 check("t3_sel", 32'(bus.s_sel), 32'h0);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t3_err1", 1'b0, 1'b1, 32'h0);
    tick();
    check_phase("t3_err2", 1'b1, 1'b1, 32'h0);
    check_err("t3", 16'd1, 32'h2000, 2'd0);
    tick();
    check_phase("t3_idle", 1'b1, 1'b0, 32'h0);

    // 4: read-only write fault, then legal read
    drive(32'h4, TransNonseq, 1'b1, 4'b0011);
    #1 check("t4_wsel", 32'(bus.s_sel), 32'h0);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t4_werr1", 1'b0, 1'b1, 32'h0);
    tick();
    check_phase("t4_werr2", 1'b1, 1'b1, 32'h0);
    check_err("t4_w", 16'd2, 32'h4, 2'd1);
    tick();
    drive(32'h4, TransNonseq, 1'b0, 4'b0011);
    bus.s_rdata[0] = 32'h0000ABCD;
    #1 check("t4_rsel", 32'(bus.s_sel), 32'h1);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t4_rdata", 1'b1, 1'b0, 32'h0000ABCD);

    // 4b: privilege check on device 1
    drive(32'h800, TransNonseq, 1'b0, 4'b0000);
    #1 check("t4_psel", 32'(bus.s_sel), 32'h0);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t4_perr1", 1'b0, 1'b1, 32'h0);
    tick();
    check_phase("t4_perr2", 1'b1, 1'b1, 32'h0);
    check_err("t4_p", 16'd3, 32'h800, 2'd2);
    tick();
    drive(32'h800, TransNonseq, 1'b0, 4'b0010);
    bus.s_rdata[1] = 32'h5555AAAA;
    #1 check("t4_okpsel", 32'(bus.s_sel), 32'h2);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t4_okp", 1'b1, 1'b0, 32'h5555AAAA);

    // 5: back-to-back unmapped, then idle/busy stream
    drive(32'h3000, TransNonseq, 1'b0, 4'b0011);
    tick();
    drive(32'h3004, TransNonseq, 1'b0, 4'b0011);
    #1 check_phase("t5_a_err1", 1'b0, 1'b1, 32'h0);
    tick();
    check_phase("t5_a_err2", 1'b1, 1'b1, 32'h0);
    check_err("t5_a", 16'd4, 32'h3000, 2'd0);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t5_b_err1", 1'b0, 1'b1, 32'h0);
    check_err("t5_b", 16'd5, 32'h3004, 2'd0);
    tick();
    check_phase("t5_b_err2", 1'b1, 1'b1, 32'h0);
    tick();
    drive(32'h2000, TransBusy, 1'b0, 4'b0011);
    #1 check_phase("t5_idle", 1'b1, 1'b0, 32'h0);
    tick();
    drive(32'h3000, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t5_busy", 1'b1, 1'b0, 32'h0);
    tick();
    check_phase("t5_idle2", 1'b1, 1'b0, 32'h0);
    check("t5_count", 32'(err_count), 32'd5);

    // 6: asynchronous reset during the first error cycle
    drive(32'h2000, TransNonseq, 1'b0, 4'b0011);
    tick();
    drive(32'h10, TransNonseq, 1'b0, 4'b0011);
    #1 check("t6_err1", 32'(bus.m_ready), 32'h0);
    #1 nreset = 1'b0;
    #1 check_phase("t6_rst", 1'b1, 1'b0, 32'h0);
    check("t6_rst_sel", 32'(bus.s_sel), 32'h0);
    check_err("t6_rst", 16'd0, 32'h0, 2'd0);
    @(negedge clock);
    nreset = 1'b1;
    bus.s_rdata[0] = 32'hDEADBEEF;
    #1 check("t6_sel", 32'(bus.s_sel), 32'h1);
    tick();
    drive(32'h0, TransIdle, 1'b0, 4'b0011);
    #1 check_phase("t6_data", 1'b1, 1'b0, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_interconnect.md
Name: ahb_interconnect

Overview:
Parametrised AHB-Lite single-master interconnect. It replaces the fixed two-device select and response path between the control unit's bus master and external slaves. It decodes a configurable address map into per-device selects and registers the data-phase owner. It muxes slave read data, ready and response back to the master. A built-in default slave returns a two-cycle ERROR for unmapped, write-protected or privilege-violating accesses, and the fault is captured in status outputs.

Parameters:
DEVICE_COUNT, 2, number of slave devices (1..16)
ADDR_BASE, '{0, 2048}, per-device region base address, 32-bit, size-aligned
ADDR_SIZE, '{2048, 2048}, per-device region size in bytes, power of two
READ_ONLY, 'b00, bit i set: writes to device i fault
PRIV_ONLY, 'b00, bit i set: accesses with m_prot[1]=0 to device i fault

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
m_addr  in  32  master address (address phase)
m_trans  in  transfer_kind  IDLE/BUSY/NONSEQ/SEQ
m_write  in  1  master write
m_prot  in  transfer_protection  bit 1 = privileged
s_sel  out  DEVICE_COUNT  per-device select
s_rdata  in  32 x DEVICE_COUNT  slave read data
s_ready  in  DEVICE_COUNT  slave ready-out
s_resp  in  transfer_response x DEVICE_COUNT  slave response
m_rdata  out  32  muxed read data to master
m_ready  out  1  muxed ready; also fed back to slaves as ready-in
m_resp  out  transfer_response  muxed response
err_count  out  16  saturating fault counter
err_addr  out  32  address of most recent fault
err_cause  out  2  0=UNMAPPED, 1=READ_ONLY, 2=PRIV

Behaviour:
- Decode (combinational): hit_i = (m_addr - ADDR_BASE[i]) < ADDR_SIZE[i], unsigned 32-bit. On overlap the lowest index wins. No hit means UNMAPPED.
- Fault, for a hit on device i:
  - m_write && READ_ONLY[i] gives cause READ_ONLY.
  - Otherwise !m_prot[1] && PRIV_ONLY[i] gives cause PRIV.
- s_sel: one-hot of the decoded device, all zero on fault or UNMAPPED. It is pure address decode and independent of m_trans. Forced to 0 while nreset is low.
- Accept: an address phase is accepted when m_ready=1 at the clock edge.
- data_sel register, updated only on accept:
  - NONE for IDLE/BUSY.
  - DEFAULT for NONSEQ/SEQ that faults.
  - Device index otherwise.
  - Reset value is NONE. Held while m_ready=0.
- Output mux by data_sel:
  - NONE: m_ready=1, m_resp=OKAY, m_rdata=0.
  - Device i: s_ready[i], s_resp[i], s_rdata[i].
  - DEFAULT: driven by the FSM below, m_rdata=0.
- Default-slave FSM (DS_IDLE, DS_ERR1, DS_ERR2), reset to DS_IDLE:
  - DS_IDLE goes to DS_ERR1 on a faulting accept.
  - DS_ERR1: m_ready=0, m_resp=ERROR; always goes to DS_ERR2.
  - DS_ERR2: m_ready=1, m_resp=ERROR. Goes to DS_ERR1 if a faulting transfer is accepted this cycle, else to DS_IDLE.
- Latency: zero-wait devices give data one cycle after address accept; a fault costs two cycles.
- Error capture on each faulting accept:
  - err_count += 1, saturating at 0xFFFF.
  - err_addr <= m_addr; err_cause <= cause.
  - Reset values are 0, 0, 0.
- Slave extending m_ready low: data_sel and the FSM hold. A new address presented during the stall is neither decoded into data_sel nor counted.
- Asynchronous reset mid-transfer: data_sel=NONE and the FSM returns to DS_IDLE immediately. Outputs become m_ready=1, m_resp=OKAY, m_rdata=0, with err_* cleared, without waiting for a clock.
- Elaboration asserts: DEVICE_COUNT in 1..16; each ADDR_SIZE a power of two; each ADDR_BASE aligned to its size.

Decomposition:
- Shared package ahb_pkg holds:
  - transfer_kind, transfer_size, transfer_burst, transfer_protection, transfer_response typedefs.
  - fault_cause enum.
  - data_sel encoding (NONE, DEFAULT, index).
- One sub-module, ahb_default_slave: the three-state FSM plus the error capture registers. Inputs are fault-accept and cause; outputs are ready and resp.

Test Plan:
1. NONSEQ read 0x0000_0010, s_ready[0]=1, s_rdata[0]=0xDEADBEEF -> s_sel=2'b01 that cycle; next cycle m_rdata=0xDEADBEEF, m_resp=OKAY, m_ready=1.
2. NONSEQ 0x0000_0900, s_ready[1] low 3 cycles, next address 0x10 held during stall -> m_ready low exactly 3 cycles, then s_rdata[1] returned; data_sel switches to device 0 only after the stall.
3. NONSEQ read 0x0000_2000 (unmapped) -> s_sel=0; next cycle ERROR/ready=0, then ERROR/ready=1; err_count=1, err_addr=0x2000, err_cause=0.
4. READ_ONLY='b01: write 0x4 -> ERROR sequence with err_cause=1; read 0x4 -> OKAY from device 0. PRIV_ONLY='b10: read 0x800 with m_prot[1]=0 -> cause 2; with m_prot[1]=1 -> OKAY.
5. Back-to-back NONSEQ to 0x3000 then 0x3004 -> FSM ERR1, ERR2, ERR1, ERR2 and err_count=2. A following stream of IDLE/BUSY -> m_ready=1, OKAY every cycle, count unchanged.
6. Assert nreset during DS_ERR1 -> same delta: m_ready=1, m_resp=OKAY, s_sel=0, err_count=0. After release, a read to 0x10 works as in test 1.
